// File: rtl/key_schedule.sv
// AES (FIPS-197) key expansion for 128/192/256-bit keys: loads Nk key words, expands
// one word per clock into a round-key store and serves registered round-key reads.

module s_box (
   input  logic [31:0] i_word,
   output logic [31:0] o_word
);
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // NOTE: blocking assignments are correct here: function locals are combinational temporaries.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] p;
      acc = 8'h00;
      p   = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

   // Multiplicative inverse as x^254 (square-and-multiply), then the affine transform.
   function automatic logic [7:0] sub_byte(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   assign o_word = {sub_byte(i_word[31:24]), sub_byte(i_word[23:16]),
                    sub_byte(i_word[15:8]),  sub_byte(i_word[7:0])};
endmodule

module key_schedule #(
   parameter int MAX_KEY_BITS = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  key_len,
   input  logic [31:0] key_word,
   input  logic        key_valid,
   output logic        key_ready,
   output logic        busy,
   output logic        done,
   output logic        err,
   input  logic [3:0]  rd_round,
   input  logic [1:0]  rd_col,
   output logic [31:0] rd_word
);
   localparam int W_MAX = (MAX_KEY_BITS >= 256) ? 60 : (MAX_KEY_BITS >= 192) ? 52 : 44;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_DONE} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [1:0]  r_klen;
   logic [5:0]  r_cnt;
   logic [2:0]  r_phase;     // i mod Nk for the word being written
   logic [7:0]  r_rcon;
   logic        r_err;
   logic [31:0] r_rd_word;
   logic [31:0] r_mem [0:W_MAX-1];
   logic [31:0] r_win [0:7]; // r_win[0] = w[i-1], r_win[Nk-1] = w[i-Nk]

   logic        w_len_ok;
   logic        w_can_start;
   logic [2:0]  w_nk_last;
   logic [3:0]  w_nr;
   logic [5:0]  w_last_idx;
   logic [31:0] w_sb_in;
   logic [31:0] w_sb_out;
   logic [31:0] w_temp;
   logic [31:0] w_new_word;
   logic [31:0] w_wr_data;
   logic        w_wr_en;
   logic        w_load_last;
   logic        w_exp_last;

   assign w_len_ok = (key_len == 2'b00) ||
                     (key_len == 2'b01 && MAX_KEY_BITS >= 192) ||
                     (key_len == 2'b10 && MAX_KEY_BITS >= 256);
   assign w_can_start = start && (r_state == S_IDLE || r_state == S_DONE);

   always_comb begin
      w_nk_last  = 3'd3;
      w_nr       = 4'd10;
      w_last_idx = 6'd43;
      case (r_klen)
         2'b01:   begin w_nk_last = 3'd5; w_nr = 4'd12; w_last_idx = 6'd51; end
         2'b10:   begin w_nk_last = 3'd7; w_nr = 4'd14; w_last_idx = 6'd59; end
         default: ;
      endcase
   end

   assign w_sb_in = (r_phase == 3'd0) ? {r_win[0][23:0], r_win[0][31:24]} : r_win[0];

   s_box u_s_box (
      .i_word (w_sb_in),
      .o_word (w_sb_out)
   );

   assign w_temp = (r_phase == 3'd0)                    ? (w_sb_out ^ {r_rcon, 24'h0}) :
                   (r_klen == 2'b10 && r_phase == 3'd4) ? w_sb_out : r_win[0];
   assign w_new_word  = r_win[w_nk_last] ^ w_temp;
   assign w_wr_data   = (r_state == S_LOAD) ? key_word : w_new_word;
   assign w_wr_en     = (r_state == S_LOAD && key_valid) || r_state == S_EXPAND;
   assign w_load_last = r_state == S_LOAD && key_valid && r_phase == w_nk_last;
   assign w_exp_last  = r_state == S_EXPAND && r_cnt == w_last_idx;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: if (start) w_next = w_len_ok ? S_LOAD : S_IDLE;
         S_LOAD:         if (w_load_last) w_next = S_EXPAND;
         S_EXPAND:       if (w_exp_last) w_next = S_DONE;
         default:        w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_klen    <= 2'b00;
         r_cnt     <= 6'd0;
         r_phase   <= 3'd0;
         r_rcon    <= 8'h01;
         r_err     <= 1'b0;
         r_rd_word <= 32'h0;
      end else begin
         r_rd_word <= (rd_round <= w_nr) ? r_mem[{rd_round, rd_col}] : 32'h0;
         if (w_can_start) begin
            if (w_len_ok) begin
               r_klen  <= key_len;
               r_err   <= 1'b0;
               r_cnt   <= 6'd0;
               r_phase <= 3'd0;
               r_rcon  <= 8'h01;
            end else begin
               r_err <= 1'b1;
            end
         end else if (w_wr_en) begin
            if (r_cnt != w_last_idx) r_cnt <= r_cnt + 6'd1;
            r_phase <= (r_phase == w_nk_last) ? 3'd0 : r_phase + 3'd1;
            if (r_state == S_EXPAND && r_phase == 3'd0)
               r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
         end
      end
   end

   // NOTE: storage is deliberately not reset; words are only meaningful once done is high.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_cnt] <= w_wr_data;
         r_win[0]     <= w_wr_data;
         for (int k = 1; k < 8; k++) r_win[k] <= r_win[k-1];
      end
   end

   assign key_ready = r_state == S_LOAD;
   assign busy      = r_state == S_LOAD || r_state == S_EXPAND;
   assign done      = r_state == S_DONE;
   assign err       = r_err;
   assign rd_word   = r_rd_word;
endmodule

// File: tb/tb_key_schedule.sv
// Self-checking bench for key_schedule: FIPS-197 vectors, random keys with key_valid gaps,
// error handling and reset recovery, checked against an arithmetic key-expansion model.

module tb_key_schedule;
   logic        clk = 1'b0;
   logic        reset, start, key_valid;
   logic [1:0]  key_len, rd_col;
   logic [3:0]  rd_round;
   logic [31:0] key_word;
   logic        key_ready, busy, done, err;
   logic [31:0] rd_word;
   logic        s_key_ready, s_busy, s_done, s_err;
   logic [31:0] s_rd_word;

   int n_checks = 0;
   int n_errors = 0;

   bit [7:0]  sbox_t [256];
   bit [31:0] m_w [60];
   bit [31:0] key [8];

   always #5 clk = ~clk;

   key_schedule dut (
      .clk(clk), .reset(reset), .start(start), .key_len(key_len), .key_word(key_word),
      .key_valid(key_valid), .key_ready(key_ready), .busy(busy), .done(done), .err(err),
      .rd_round(rd_round), .rd_col(rd_col), .rd_word(rd_word)
   );

   key_schedule #(.MAX_KEY_BITS(128)) dut_s (
      .clk(clk), .reset(reset), .start(start), .key_len(key_len), .key_word(key_word),
      .key_valid(key_valid), .key_ready(s_key_ready), .busy(s_busy), .done(s_done), .err(s_err),
      .rd_round(rd_round), .rd_col(rd_col), .rd_word(s_rd_word)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit [7:0] xt(input bit [7:0] a);
      bit [8:0] d;
      d = {1'b0, a} * 9'd2;
      return d[8] ? (d[7:0] ^ 8'h1b) : d[7:0];
   endfunction

   function automatic bit [7:0] rotl8(input bit [7:0] v, input int n);
      bit [15:0] d;
      d = {v, v} << n;
      return d[15:8];
   endfunction

   // S-box from exp/log tables of generator 3, then the FIPS-197 affine map.
   task automatic build_sbox();
      bit [7:0] ex [255];
      int       lg [256];
      bit [7:0] p;
      bit [7:0] inv;
      p = 8'h01;
      for (int i = 0; i < 255; i++) begin
         ex[i] = p;
         lg[p] = i;
         p = p ^ xt(p);
      end
      sbox_t[0] = 8'h63;
      for (int x = 1; x < 256; x++) begin
         inv = ex[(255 - lg[x]) % 255];
         sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic bit [31:0] subw(input bit [31:0] t);
      return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
   endfunction

   task automatic model_expand(input int nk);
      int       nw;
      bit [7:0] rc;
      bit [31:0] t;
      nw = 4 * (nk + 7);
      rc = 8'h01;
      for (int i = 0; i < nk; i++) m_w[i] = key[i];
      for (int i = nk; i < nw; i++) begin
         t = m_w[i-1];
         if (i % nk == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end else if (nk == 8 && i % 8 == 4) begin
            t = subw(t);
         end
         m_w[i] = m_w[i-nk] ^ t;
      end
   endtask

   task automatic read_word(input int r, input int c, output logic [31:0] d);
      rd_round = 4'(r);
      rd_col   = 2'(c);
      @(posedge clk); #1;
      d = rd_word;
   endtask

   // Start a schedule, feed the key (gap_pct % idle cycles), check latency and all words.
   task automatic run_schedule(input string name, input bit [1:0] kl, input int gap_pct);
      int nk, nw, nr, edges, gaps, j, done_at;
      bit rdy;
      logic [31:0] d;
      nk = (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
      nr = nk + 6;
      nw = 4 * (nr + 1);
      edges = 0; gaps = 0; j = 0; done_at = -1;
      model_expand(nk);
      start = 1'b1; key_len = kl; key_valid = 1'b1; key_word = key[0];
      @(posedge clk); #1;
      start = 1'b0;
      while (j < nk && edges < 1000) begin
         key_word  = key[j];
         key_valid = (gap_pct == 0) ? 1'b1 : ($urandom_range(99) >= gap_pct);
         rdy = key_ready;
         if (!key_valid) gaps++;
         @(posedge clk); edges++; #1;
         if (key_valid && rdy) j++;
         if (done && done_at < 0) done_at = edges;
      end
      key_valid = 1'b0;
      while (done_at < 0 && edges < nw + gaps + 20) begin
         @(posedge clk); edges++; #1;
         if (done) done_at = edges;
      end
      check($sformatf("%s latency", name), done_at, nw + gaps);
      check($sformatf("%s busy", name), busy, 0);
      check($sformatf("%s key_ready", name), key_ready, 0);
      check($sformatf("%s err", name), err, 0);
      for (int r = 0; r <= nr; r++)
         for (int c = 0; c < 4; c++) begin
            read_word(r, c, d);
            check($sformatf("%s w[%0d]", name, 4*r + c), d, m_w[4*r + c]);
         end
      read_word(nr + 1, 0, d);
      check($sformatf("%s round %0d", name, nr + 1), d, 0);
      check($sformatf("%s done held", name), done, 1);
   endtask

   task automatic set_fips128();
      key[0] = 32'h2b7e1516; key[1] = 32'h28aed2a6; key[2] = 32'habf71588; key[3] = 32'h09cf4f3c;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      build_sbox();
      reset = 1'b1; start = 1'b0; key_len = 2'b00; key_word = 32'h0; key_valid = 1'b0;
      rd_round = 4'd0; rd_col = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset outputs", {key_ready, busy, done, err}, 0);
      check("reset rd_word", rd_word, 0);
      check("reset small outputs", {s_key_ready, s_busy, s_done, s_err}, 0);
      reset = 1'b0;

      set_fips128();
      run_schedule("fips128", 2'd0, 0);
      read_word(1, 0, d);  check("fips128 w4", d, 32'ha0fafe17);
      read_word(10, 3, d); check("fips128 w43", d, 32'hb6630ca6);

      key[0] = 32'h8e73b0f7; key[1] = 32'hda0e6452; key[2] = 32'hc810f32b;
      key[3] = 32'h809079e5; key[4] = 32'h62f8ead2; key[5] = 32'h522c6b7b;
      run_schedule("fips192", 2'd1, 0);
      read_word(1, 2, d);  check("fips192 w6", d, 32'hfe0c91f7);
      read_word(12, 3, d); check("fips192 w51", d, 32'h01002202);

      key[0] = 32'h603deb10; key[1] = 32'h15ca71be; key[2] = 32'h2b73aef0; key[3] = 32'h857d7781;
      key[4] = 32'h1f352c07; key[5] = 32'h3b6108d7; key[6] = 32'h2d9810a3; key[7] = 32'h0914dff4;
      run_schedule("fips256", 2'd2, 0);
      read_word(2, 0, d);  check("fips256 w8", d, 32'h9ba35411);
      read_word(14, 3, d); check("fips256 w59", d, 32'h706c631e);

      set_fips128();
      run_schedule("gap128", 2'd0, 50);
      read_word(10, 3, d); check("gap128 w43", d, 32'hb6630ca6);

      // Reserved key length from DONE: error, back to IDLE.
      start = 1'b1; key_len = 2'b11;
      @(posedge clk); #1;
      start = 1'b0;
      check("bad len err", err, 1);
      check("bad len busy", busy, 0);
      check("bad len done", done, 0);

      // 256-bit request on the 128-only instance; the full instance starts loading.
      start = 1'b1; key_len = 2'b10;
      @(posedge clk); #1;
      start = 1'b0;
      check("small err", s_err, 1);
      check("small busy", s_busy, 0);
      check("small done", s_done, 0);
      check("full err cleared", err, 0);

      // Let the full instance reach EXPAND, then reset mid-schedule.
      key_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         key_word = $urandom;
         @(posedge clk); #1;
      end
      key_valid = 1'b0;
      check("mid expand busy", {busy, key_ready}, 2'b10);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort outputs", {key_ready, busy, done, err}, 0);
      check("abort small err", s_err, 0);
      set_fips128();
      run_schedule("recover128", 2'd0, 0);
      read_word(1, 0, d);  check("recover128 w4", d, 32'ha0fafe17);
      read_word(11, 0, d); check("recover128 round11", d, 0);
      check("small done", s_done, 1);
      read_word(10, 3, d); check("small w43", s_rd_word, 32'hb6630ca6);

      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < 8; i++) key[i] = $urandom;
         run_schedule($sformatf("rand%0d", t), 2'($urandom_range(2)), 25);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
